// File: rtl/ram16_word_ctrl.sv
// 32-bit word read/write sequencer over a 16-bit halfword-addressed synchronous RAM.
// Define RAM16_UNALIGNED_EN to allow odd word addresses (second halfword wraps modulo 2^AW).
module ram16_word_ctrl #(
  parameter int AW     = 4,
  parameter int RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  input  logic          req_le,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic [31:0]   resp_rdata,
  output logic          resp_err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [15:0]   mem_wdata,
  input  logic [15:0]   mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACC0,
    S_ACC1,
    S_WAIT,
    S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic          le_q, le_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [15:0]   half0_cap_q, half0_cap_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [15:0]   mem_wdata_q, mem_wdata_d;
  logic          resp_valid_q, resp_valid_d;
  logic          resp_err_q, resp_err_d;
  logic [31:0]   resp_rdata_q, resp_rdata_d;
  logic          misaligned;

`ifdef RAM16_UNALIGNED_EN
  assign misaligned = 1'b0;
`else
  assign misaligned = req_addr[0];
`endif

  // Big-endian puts the upper halfword first; little-endian puts it second.
  function automatic logic [15:0] pick_half(input logic [31:0] w, input logic upper);
    return upper ? w[31:16] : w[15:0];
  endfunction

  // cnt counts cycles since ACC0, so half0 arrives at cnt==RD_LAT and half1 one later.
  always_comb begin
    // NOTE: every variable gets a default here so no path can leave it unassigned and infer a latch.
    state_d      = state_q;
    we_d         = we_q;
    le_d         = le_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    half0_cap_d  = half0_cap_q;
    cnt_d        = cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_rdata_d = resp_rdata_q;

    if ((state_q == S_ACC1 || state_q == S_WAIT) && cnt_q == 3'(RD_LAT)) begin
      half0_cap_d = mem_rdata;
    end

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          le_d    = req_le;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (misaligned) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
          end else begin
            state_d    = S_ACC0;
            cnt_d      = '0;
            mem_addr_d = req_addr;
            mem_we_d   = req_we;
            if (req_we) mem_wdata_d = pick_half(req_wdata, !req_le);
          end
        end
      end
      S_ACC0: begin
        state_d    = S_ACC1;
        cnt_d      = cnt_q + 3'd1;
        mem_addr_d = addr_q + AW'(1);
        mem_we_d   = we_q;
        if (we_q) mem_wdata_d = pick_half(wdata_q, le_q);
      end
      S_ACC1: begin
        cnt_d = cnt_q + 3'd1;
        if (we_q) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'(RD_LAT + 1)) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          resp_err_d   = 1'b0;
          resp_rdata_d = le_q ? {mem_rdata, half0_cap_q} : {half0_cap_q, mem_rdata};
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d      = S_IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_rdata_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Reset drops mem_we asynchronously so an interrupted write never completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      le_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      half0_cap_q  <= '0;
      cnt_q        <= '0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge values.
      state_q      <= state_d;
      we_q         <= we_d;
      le_q         <= le_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      half0_cap_q  <= half0_cap_d;
      cnt_q        <= cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_rdata = resp_rdata_q;
  assign mem_addr   = mem_addr_q;
  assign mem_we     = mem_we_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_ram16_word_ctrl.sv
// Bench for ram16_word_ctrl: two instances (RD_LAT=1 and RD_LAT=3), each with its own RAM model,
// driven by directed steps with a scoreboard of expected responses.
module tb_ram16_word_ctrl;

  localparam int AW = 4;

  typedef struct {
    int          k;
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic          clk;
  logic          rst_n;
  logic          preload;
  logic [1:0]    req_valid, req_ready, req_we, req_le;
  logic [1:0]    resp_valid, resp_ready, resp_err, mem_we;
  logic [AW-1:0] req_addr [2];
  logic [AW-1:0] mem_addr [2];
  logic [31:0]   req_wdata [2];
  logic [31:0]   resp_rdata [2];
  logic [15:0]   mem_wdata [2];
  logic [15:0]   mem_rdata [2];
  logic [15:0]   ram [2][16];
  logic [15:0]   pipe [2][3];
  int            we_cnt [2];
  int            cyc;
  int            acc_cyc [2];
  int            n_vec, n_miss;
  exp_t          sb[$];

  ram16_word_ctrl #(.AW(AW), .RD_LAT(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_le(req_le[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0]), .mem_addr(mem_addr[0]), .mem_we(mem_we[0]),
    .mem_wdata(mem_wdata[0]), .mem_rdata(mem_rdata[0])
  );

  ram16_word_ctrl #(.AW(AW), .RD_LAT(3)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_le(req_le[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1]), .mem_addr(mem_addr[1]), .mem_we(mem_we[1]),
    .mem_wdata(mem_wdata[1]), .mem_rdata(mem_rdata[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] init_val(input int i);
    if (i < 4) return {8'(2 * i), 8'(2 * i + 1)};
    if (i == 15) return 16'hABCD;
    return {8'hE0, 8'(i)};
  endfunction

  // RAM models: read-before-write, output delayed by a 1- or 3-stage pipe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int k = 0; k < 2; k++) begin
      if (preload) begin
        for (int i = 0; i < 16; i++) ram[k][i] <= init_val(i);
      end else if (mem_we[k]) begin
        ram[k][mem_addr[k]] <= mem_wdata[k];
      end
      if (mem_we[k]) we_cnt[k] <= we_cnt[k] + 1;
      pipe[k][0] <= ram[k][mem_addr[k]];
      pipe[k][1] <= pipe[k][0];
      pipe[k][2] <= pipe[k][1];
    end
  end

  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int k, input logic we, input logic [AW-1:0] addr,
                      input logic [31:0] wdata, input logic le,
                      input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int n;
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_le[k]    = le;
    n = 0;
    while (!req_ready[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("accept_in_time", 64'(n < 20), 64'(1));
    acc_cyc[k] = cyc;
    sb.push_back('{k, exp_rdata, exp_err, exp_lat});
    @(negedge clk);
    req_valid[k] = 1'b0;
  endtask

  task automatic recv(input int k, input string tag);
    int   n;
    exp_t e;
    n = 0;
    while (!resp_valid[k] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_resp_in_time"}, 64'(n < 20), 64'(1));
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_lat"}, 64'(cyc - acc_cyc[k]), 64'(e.lat));
      check({tag, "_rdata"}, 64'(resp_rdata[k]), 64'(e.rdata));
      check({tag, "_err"}, 64'(resp_err[k]), 64'(e.err));
    end
    resp_ready[k] = 1'b1;
    @(negedge clk);
    resp_ready[k] = 1'b0;
    check({tag, "_cleared"}, {resp_valid[k], resp_err[k], resp_rdata[k]}, 64'(0));
    check({tag, "_ready_again"}, 64'(req_ready[k]), 64'(1));
  endtask

  initial begin
    int   w, n;
    exp_t e;
    n_vec = 0;
    n_miss = 0;
    cyc = 0;
    we_cnt[0] = 0;
    we_cnt[1] = 0;
    rst_n = 1'b0;
    preload = 1'b1;
    req_valid = '0;
    req_we = '0;
    req_le = '0;
    resp_ready = '0;
    for (int k = 0; k < 2; k++) begin
      req_addr[k] = '0;
      req_wdata[k] = '0;
    end
    repeat (2) @(negedge clk);
    preload = 1'b0;
    check("rst_req_ready", 64'(req_ready), 64'(2'b11));
    check("rst_resp", {resp_valid, resp_err, resp_rdata[0]}, 64'(0));
    check("rst_mem", {mem_we[0], mem_addr[0], mem_wdata[0]}, 64'(0));
    rst_n = 1'b1;

    // Basic reads at RD_LAT=1; no write strobe allowed.
    w = we_cnt[0];
    send(0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h00010203, 1'b0, 4);
    recv(0, "rd0_be");
    check("rd0_no_we", 64'(we_cnt[0] - w), 64'(0));
    send(0, 1'b0, 4'd2, 32'h0, 1'b1, 32'h06070405, 1'b0, 4);
    recv(0, "rd2_le");

    // Writes in both orders, then read back.
    w = we_cnt[0];
    send(0, 1'b1, 4'd4, 32'h41424344, 1'b0, 32'h0, 1'b0, 3);
    recv(0, "wr4_be");
    check("wr4_we_pulses", 64'(we_cnt[0] - w), 64'(2));
    check("wr4_mem4", 64'(ram[0][4]), 64'(16'h4142));
    check("wr4_mem5", 64'(ram[0][5]), 64'(16'h4344));
    send(0, 1'b0, 4'd4, 32'h0, 1'b0, 32'h41424344, 1'b0, 4);
    recv(0, "rd4_be");
    send(0, 1'b1, 4'd6, 32'h41424344, 1'b1, 32'h0, 1'b0, 3);
    recv(0, "wr6_le");
    check("wr6_mem6", 64'(ram[0][6]), 64'(16'h4344));
    check("wr6_mem7", 64'(ram[0][7]), 64'(16'h4142));
    send(0, 1'b0, 4'd6, 32'h0, 1'b1, 32'h41424344, 1'b0, 4);
    recv(0, "rd6_le");

    // Odd addresses: rejected by default, wrap-around pairing when enabled.
    w = we_cnt[0];
`ifdef RAM16_UNALIGNED_EN
    send(0, 1'b0, 4'd1, 32'h0, 1'b0, 32'h02030405, 1'b0, 4);
    recv(0, "rd1_odd");
    send(0, 1'b0, 4'd15, 32'h0, 1'b0, 32'hABCD0001, 1'b0, 4);
    recv(0, "rd15_wrap");
`else
    send(0, 1'b0, 4'd1, 32'h0, 1'b0, 32'h0, 1'b1, 1);
    recv(0, "rd1_err");
    send(0, 1'b1, 4'd15, 32'hDEADBEEF, 1'b0, 32'h0, 1'b1, 1);
    recv(0, "wr15_err");
    check("odd_no_we", 64'(we_cnt[0] - w), 64'(0));
    check("odd_mem15_kept", 64'(ram[0][15]), 64'(16'hABCD));
`endif

    // RD_LAT=3 instance.
    send(1, 1'b0, 4'd2, 32'h0, 1'b1, 32'h06070405, 1'b0, 6);
    recv(1, "l3_rd2_le");
    send(1, 1'b0, 4'd0, 32'h0, 1'b0, 32'h00010203, 1'b0, 6);
    recv(1, "l3_rd0_be");
    send(1, 1'b1, 4'd10, 32'h12345678, 1'b0, 32'h0, 1'b0, 3);
    recv(1, "l3_wr10");
    send(1, 1'b0, 4'd10, 32'h0, 1'b1, 32'h56781234, 1'b0, 6);
    recv(1, "l3_rd10_le");
    send(1, 1'b0, 4'd14, 32'h0, 1'b0, 32'hE00EABCD, 1'b0, 6);
    recv(1, "l3_rd14_top");

    // Back-pressure with a second request pending.
    send(0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h00010203, 1'b0, 4);
    req_valid[0] = 1'b1;
    req_we[0]    = 1'b0;
    req_addr[0]  = 4'd2;
    req_le[0]    = 1'b0;
    n = 0;
    while (!resp_valid[0] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hold_resp_in_time", 64'(n < 20), 64'(1));
    e = sb.pop_front();
    check("hold_lat", 64'(cyc - acc_cyc[0]), 64'(e.lat));
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 64'(resp_valid[0]), 64'(1));
      check("hold_rdata", 64'(resp_rdata[0]), 64'(e.rdata));
      check("hold_busy", 64'(req_ready[0]), 64'(0));
      @(negedge clk);
    end
    resp_ready[0] = 1'b1;
    @(negedge clk);
    resp_ready[0] = 1'b0;
    check("hold_next_ready", 64'(req_ready[0]), 64'(1));
    check("hold_resp_cleared", 64'(resp_valid[0]), 64'(0));
    acc_cyc[0] = cyc;
    sb.push_back('{0, 32'h04050607, 1'b0, 4});
    @(negedge clk);
    req_valid[0] = 1'b0;
    recv(0, "pend_rd2");

    // Reset in the middle of ACC1 of a write to addr 8.
    send(0, 1'b1, 4'd8, 32'h55667788, 1'b0, 32'h0, 1'b0, 3);
    @(negedge clk);
    check("rst_mid_pre_we", 64'(mem_we[0]), 64'(1));
    check("rst_mid_pre_addr", 64'(mem_addr[0]), 64'(9));
    rst_n = 1'b0;
    #1;
    check("rst_mid_we", 64'(mem_we[0]), 64'(0));
    check("rst_mid_outs", {req_ready[0], resp_valid[0], resp_err[0], mem_addr[0], mem_wdata[0]},
          64'({1'b1, 1'b0, 1'b0, 4'd0, 16'd0}));
    check("rst_mid_rdata", 64'(resp_rdata[0]), 64'(0));
    sb.delete();
    repeat (2) @(negedge clk);
    check("rst_mem8_written", 64'(ram[0][8]), 64'(16'h5566));
    check("rst_mem9_kept", 64'(ram[0][9]), 64'(16'hE009));
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_rel_ready", 64'(req_ready[0]), 64'(1));
    send(0, 1'b0, 4'd0, 32'h0, 1'b0, 32'h00010203, 1'b0, 4);
    recv(0, "post_rst_rd0");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram16_word_ctrl.md
Name: ram16_word_ctrl

Overview:
Sequencer that performs 32-bit word reads/writes on a 16-bit-wide, halfword-addressed synchronous RAM (the 16-bit register/RAM store) using two back-to-back halfword accesses.
- Applies per-request halfword endian ordering.
- Rejects misaligned addresses unless the optional feature is compiled in.
- Sits between a requester (CPU stub / display readout logic) and the RAM; single outstanding request, valid/ready handshakes on both sides.

Parameters:
AW, 4, RAM halfword address width (2^AW halfwords).
RD_LAT, 1, RAM read latency in cycles (legal 1..3): mem_rdata for an address presented in cycle n is valid in cycle n+RD_LAT.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  controller idle, request accepted when req_valid&&req_ready.
req_we  in  1  1=write, 0=read.
req_addr  in  AW  halfword address of word's first halfword.
req_wdata  in  32  write word.
req_le  in  1  1=little-endian halfword order, 0=big.
resp_valid  out  1  response available.
resp_ready  in  1  response consumed when resp_valid&&resp_ready.
resp_rdata  out  32  read word (0 for writes/errors).
resp_err  out  1  misaligned request rejected.
mem_addr  out  AW  RAM address.
mem_we  out  1  RAM write strobe.
mem_wdata  out  16  RAM write halfword.
mem_rdata  in  16  RAM read halfword.

Behaviour:
- Reset (async, rst_n=0): state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_addr=0, mem_we=0, mem_wdata=0. Any in-flight op is abandoned. mem_we falls immediately, with no further RAM write.
- FSM: IDLE -> ACC0 -> ACC1 -> (read: WAIT) -> RESP -> IDLE. Error path: IDLE -> RESP.
- IDLE: req_ready=1. On accept, latch we, addr, wdata, le.
  - a0=addr, a1=(addr+1) mod 2^AW.
  - Big-endian (le=0): half0=word[31:16] at a0, half1=word[15:0] at a1.
  - Little-endian (le=1): half0=word[15:0] at a0, half1=word[31:16] at a1.
  - Ordering is halfword-level only; bytes within a halfword are never swapped.
- ACC0 (1 cycle): mem_addr=a0; mem_we=we; mem_wdata=half0 if write.
- ACC1 (1 cycle): mem_addr=a1; mem_we=we; mem_wdata=half1 if write. Write -> RESP; read -> WAIT.
- mem_we is 1 only in ACC0/ACC1 of a write. mem_addr/mem_wdata hold their last values elsewhere.
- Read capture:
  - half0 sampled from mem_rdata in the cycle ACC0+RD_LAT.
  - half1 sampled in the cycle ACC1+RD_LAT.
  - WAIT lasts until half1 is captured (RD_LAT cycles after ACC1; counter-based).
  - Captures are assembled per the latched le into resp_rdata.
- RESP: resp_valid=1; resp_rdata/resp_err stable until resp_ready. On handshake -> IDLE, with resp_valid, resp_err and resp_rdata cleared in that transition.
- req_ready=0 in every state but IDLE. Requests arriving while busy are not accepted and not dropped; the requester holds them.
- Latency, accept cycle = 0:
  - Write: resp_valid in cycle 3.
  - Read: resp_valid in cycle 3+RD_LAT (cycle 4 at default).
  - Next request acceptable the cycle after the response handshake.
- Misalignment: req_addr[0]=1 without the optional feature -> no RAM access (mem_we stays 0), resp_err=1, resp_rdata=0, resp_valid in cycle 1.
- Aligned address 2^AW-2 needs no wrap; a1=2^AW-1.

Optional Feature:
- Macro RAM16_UNALIGNED_EN.
  - Defined: odd req_addr allowed; processed exactly like aligned; a1 wraps modulo 2^AW (addr 2^AW-1 pairs with 0); resp_err never asserted.
  - Undefined: odd addresses rejected as above.

Test Plan:
- RAM preload mem[0..3]=0001,0203,0405,0607 (hex), RD_LAT=1. Read addr 0, le=0 -> resp_rdata=00010203 in cycle 4 after accept, resp_err=0, mem_we never 1.
- Read addr 2, le=1 -> resp_rdata=06070405. Repeat with RD_LAT=3 -> same data, resp_valid in cycle 6.
- Write addr 4, 41424344, le=0 -> mem[4]=4142, mem[5]=4344, resp_valid cycle 3. Read back le=0 -> 41424344. Write le=1 at addr 6 -> mem[6]=4344, mem[7]=4142.
- Read addr 1 without macro -> resp_err=1, resp_rdata=0, no mem_we pulse. With RAM16_UNALIGNED_EN, AW=4, mem[15]=ABCD: read addr 15, le=0 -> ABCD0001.
- Hold resp_ready=0 for 5 cycles with a second req_valid pending -> resp_valid/resp_rdata stable, req_ready=0. Second request accepted the cycle after resp_ready=1.
- Assert rst_n=0 mid-cycle during ACC1 of a write to addr 8 -> mem_we=0 immediately, mem[9] unchanged, all outputs at reset values. After release, req_ready=1 and a read of addr 0 returns 00010203.
